// File: rtl/reg_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : reg_cmd_sequencer_if
// Purpose   : Request handshake plus register-bank command lines of the
//             register command sequencer, bundled into one port.
// Signals   : reqValid/reqReady/reqOp/reqSel/reqData  - request handshake
//             regEnable/funSel/I                      - register commands
//             busy/done/shadowOut                     - status
// Modports  : master - request initiator (control path / testbench)
//             slave  - the sequencer itself
// Revision  : 1.0 - initial release
// ============================================================================
interface reg_cmd_sequencer_if #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2
);
    logic                reqValid;
    logic                reqReady;
    logic [1:0]          reqOp;
    logic [SEL_W-1:0]    reqSel;
    logic [15:0]         reqData;
    logic [NUM_REGS-1:0] regEnable;
    logic [1:0]          funSel;
    logic [15:0]         I;
    logic                busy;
    logic                done;
    logic [15:0]         shadowOut;

    modport master (
        output reqValid, reqOp, reqSel, reqData,
        input  reqReady, regEnable, funSel, I, busy, done, shadowOut
    );

    modport slave (
        input  reqValid, reqOp, reqSel, reqData,
        output reqReady, regEnable, funSel, I, busy, done, shadowOut
    );
endinterface
`default_nettype wire

// File: rtl/reg_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module    : reg_cmd_sequencer
// Purpose   : Accepts one register operation per handshake and drives the
//             per-register enable / funSel / I lines of the 16-bit register
//             bank. Inc/dec by N is expanded into N single-step commands.
// Ports     : clock - rising-edge clock
//             reset - asynchronous, active-high
//             bus   - reg_cmd_sequencer_if.slave (request + command lines)
// Option    : REG_SEQ_SHADOW_EN - when defined, keeps a shadow copy of every
//             register and reports the last targeted one on shadowOut;
//             otherwise shadowOut is tied to zero.
// Revision  : 1.0 - initial release
// ============================================================================
module reg_cmd_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2,
    parameter int STEP_W   = 4
) (
    input  wire logic         clock,
    input  wire logic         reset,
    reg_cmd_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic [STEP_W-1:0]   cnt_q,        cnt_d;
    logic [NUM_REGS-1:0] reg_enable_q, reg_enable_d;
    logic [1:0]          fun_sel_q,    fun_sel_d;
    logic [15:0]         i_data_q,     i_data_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;

    logic                w_accept;
    logic [STEP_W-1:0]   w_steps;

    // Ready is decoded, not registered, so it drops the moment reset rises.
    assign bus.reqReady = (state_q == S_IDLE) && !reset;
    assign w_accept     = bus.reqValid && bus.reqReady;

    // Load and clear are single commands; inc/dec use the low data bits.
    assign w_steps = bus.reqOp[1] ? STEP_W'(1) : bus.reqData[STEP_W-1:0];

`ifdef REG_SEQ_SHADOW_EN
    logic [SEL_W-1:0] sel_q,        sel_d;
    logic [15:0]      shadow_q [NUM_REGS];
    logic [15:0]      shadow_d [NUM_REGS];
    logic [15:0]      shadow_out_q, shadow_out_d;

    function automatic logic [15:0] f_apply(input logic [1:0]  op,
                                            input logic [15:0] v,
                                            input logic [15:0] d);
        case (op)
            2'b00:   f_apply = v - 16'd1;
            2'b01:   f_apply = v + 16'd1;
            2'b10:   f_apply = d;
            default: f_apply = 16'h0000;
        endcase
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        reg_enable_d = reg_enable_q;
        fun_sel_d    = fun_sel_q;
        i_data_d     = i_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef REG_SEQ_SHADOW_EN
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        shadow_out_d = 16'h0000;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    fun_sel_d = bus.reqOp;
                    i_data_d  = (bus.reqOp == 2'b10) ? bus.reqData : 16'h0000;
                    cnt_d     = w_steps;
                    busy_d    = 1'b1;
`ifdef REG_SEQ_SHADOW_EN
                    sel_d     = bus.reqSel;
`endif
                    if (w_steps == '0) begin
                        // Zero-step inc/dec: report completion, issue nothing.
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        reg_enable_d = '0;
                    end else begin
                        state_d = S_ISSUE;
                        // Out-of-range selects shift the one-hot off the top,
                        // leaving an all-zero enable for the whole sequence.
                        reg_enable_d = NUM_REGS'(1) << bus.reqSel;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q - STEP_W'(1);
`ifdef REG_SEQ_SHADOW_EN
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (sel_q == SEL_W'(r)) begin
                        shadow_d[r] = f_apply(fun_sel_q, shadow_q[r], i_data_q);
                    end
                end
`endif
                if (cnt_q == STEP_W'(1)) begin
                    state_d      = S_DONE;
                    reg_enable_d = '0;
                    done_d       = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d      = S_IDLE;
                reg_enable_d = '0;
                busy_d       = 1'b0;
            end
        endcase
`ifdef REG_SEQ_SHADOW_EN
        // Follows the post-update shadow so the final step shows in DONE.
        for (int r = 0; r < NUM_REGS; r++) begin
            if (sel_q == SEL_W'(r)) begin
                shadow_out_d = shadow_d[r];
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            reg_enable_q <= '0;
            fun_sel_q    <= 2'b00;
            i_data_q     <= 16'h0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_enable_q <= reg_enable_d;
            fun_sel_q    <= fun_sel_d;
            i_data_q     <= i_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef REG_SEQ_SHADOW_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_q        <= '0;
            shadow_out_q <= 16'h0000;
            for (int r = 0; r < NUM_REGS; r++) begin
                shadow_q[r] <= 16'h0000;
            end
        end else begin
            sel_q        <= sel_d;
            shadow_out_q <= shadow_out_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                shadow_q[r] <= shadow_d[r];
            end
        end
    end

    assign bus.shadowOut = shadow_out_q;
`else
    assign bus.shadowOut = 16'h0000;
`endif

    assign bus.regEnable = reg_enable_q;
    assign bus.funSel    = fun_sel_q;
    assign bus.I         = i_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
`default_nettype wire
